// File: rtl/mmio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_pkg : shared address map, register offsets and region decode    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF0000;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_SW     = 8'h04;
  localparam logic [7:0] OFF_SEG    = 8'h08;
  localparam logic [7:0] OFF_TCTRL  = 8'h10;
  localparam logic [7:0] OFF_TLOAD  = 8'h14;
  localparam logic [7:0] OFF_TCOUNT = 8'h18;

  localparam int TCTRL_EN     = 0;
  localparam int TCTRL_RELOAD = 1;
  localparam int TCTRL_EXP    = 2;
  localparam int TCTRL_IE     = 3;

  typedef enum logic [1:0] {
    REGION_UNMAPPED = 2'd0,
    REGION_RAM      = 2'd1,
    REGION_MMIO     = 2'd2
  } region_e;

  // RAM occupies the bottom 2^(ram_aw+2) bytes of the first 64 KiB page.
  function automatic region_e decode_region(input logic [31:0] a, input int unsigned ram_aw);
    logic [15:0] above_ram;
    above_ram = a[15:0] >> (ram_aw + 2);
    if (a[31:16] == 16'h0000 && above_ram == 16'h0000) return REGION_RAM;
    if (a[31:8] == MMIO_BASE[31:8]) return REGION_MMIO;
    return REGION_UNMAPPED;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_timer : down-counter with optional reload, sticky EXP and irq   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_tctrl_i,
  input  logic        we_tload_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] tctrl_o,
  output logic [31:0] tload_o,
  output logic [31:0] tcount_o,
  output logic        irq_o
);

  logic        en_q, en_d;
  logic        reload_q, reload_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic [31:0] tload_q, tload_d;
  logic [31:0] tcount_q, tcount_d;
  logic        expire;

  always_comb begin
    tcount_d = tcount_q;
    if (we_tload_i) begin
      tcount_d = wdata_i;
    end else if (en_q && tcount_q != 32'd0) begin
      tcount_d = tcount_q - 32'd1;
    end else if (en_q && reload_q) begin
      tcount_d = tload_q;
    end
  end

  assign expire = (tcount_q == 32'd1) && (tcount_d == 32'd0);

  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    tload_d  = tload_q;
    exp_d    = exp_q;
    if (we_tctrl_i) begin
      en_d     = wdata_i[TCTRL_EN];
      reload_d = wdata_i[TCTRL_RELOAD];
      ie_d     = wdata_i[TCTRL_IE];
      if (wdata_i[TCTRL_EXP]) exp_d = 1'b0;
    end
    if (we_tload_i) tload_d = wdata_i;
    // An expiry on the same edge as a clear must not be lost.
    if (expire) exp_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
      tload_q  <= 32'd0;
      tcount_q <= 32'd0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      exp_q    <= exp_d;
      tload_q  <= tload_d;
      tcount_q <= tcount_d;
    end
  end

  always_comb begin
    tctrl_o               = 32'd0;
    tctrl_o[TCTRL_EN]     = en_q;
    tctrl_o[TCTRL_RELOAD] = reload_q;
    tctrl_o[TCTRL_EXP]    = exp_q;
    tctrl_o[TCTRL_IE]     = ie_q;
  end

  assign tload_o  = tload_q;
  assign tcount_o = tcount_q;
  assign irq_o    = exp_q & ie_q;

endmodule
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_bridge : CPU address decode to RAM, board registers and timer;  |
// |               timer compiled in only when MMIO_TIMER_EN is defined   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       adr,
  input  logic [31:0]       writedata,
  input  logic              MemWrite,
  output logic [31:0]       readdata,
  output logic              mem_we,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output logic [31:0]       seg,
  output logic              irq
);

  region_e     region;
  logic [7:0]  offset;
  logic        mmio_wr;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic [31:0] mmio_rdata;
  logic [31:0] tctrl_rd, tload_rd, tcount_rd;

  assign region    = decode_region(adr, RAM_AW);
  assign offset    = adr[7:0];
  assign mmio_wr   = MemWrite && (region == REGION_MMIO);

  assign mem_we    = MemWrite && (region == REGION_RAM);
  assign mem_addr  = adr[RAM_AW+1:2];
  assign mem_wdata = writedata;

  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    if (mmio_wr && offset == OFF_LED) led_d = writedata[15:0];
    if (mmio_wr && offset == OFF_SEG) seg_d = writedata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= 16'd0;
      seg_q     <= 32'd0;
      sw_meta_q <= 16'd0;
      sw_sync_q <= 16'd0;
    end else begin
      led_q     <= led_d;
      seg_q     <= seg_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign led = led_q;
  assign seg = seg_q;

`ifdef MMIO_TIMER_EN
  mmio_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .we_tctrl_i (mmio_wr && offset == OFF_TCTRL),
    .we_tload_i (mmio_wr && offset == OFF_TLOAD),
    .wdata_i    (writedata),
    .tctrl_o    (tctrl_rd),
    .tload_o    (tload_rd),
    .tcount_o   (tcount_rd),
    .irq_o      (irq)
  );
`else
  assign tctrl_rd  = 32'd0;
  assign tload_rd  = 32'd0;
  assign tcount_rd = 32'd0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    mmio_rdata = 32'd0;
    case (offset)
      OFF_LED:    mmio_rdata = {16'd0, led_q};
      OFF_SW:     mmio_rdata = {16'd0, sw_sync_q};
      OFF_SEG:    mmio_rdata = seg_q;
      OFF_TCTRL:  mmio_rdata = tctrl_rd;
      OFF_TLOAD:  mmio_rdata = tload_rd;
      OFF_TCOUNT: mmio_rdata = tcount_rd;
      default:    mmio_rdata = 32'd0;
    endcase
  end

  always_comb begin
    readdata = 32'd0;
    case (region)
      REGION_RAM:  readdata = mem_rdata;
      REGION_MMIO: readdata = mmio_rdata;
      default:     readdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mmio_bridge : scoreboard bench with behavioural reference model   |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_mmio_bridge;

`ifdef MMIO_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] adr, writedata, readdata, mem_wdata, mem_rdata, seg;
  logic        MemWrite, mem_we, irq;
  logic [9:0]  mem_addr;
  logic [15:0] sw, led;

  mmio_bridge #(.RAM_AW(10)) dut (
    .clk(clk), .rst(rst), .adr(adr), .writedata(writedata), .MemWrite(MemWrite),
    .readdata(readdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sw(sw), .led(led), .seg(seg), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: combinational read, written by the DUT's RAM port.
  logic [31:0] tb_ram [0:1023];
  assign mem_rdata = tb_ram[mem_addr];
  always @(posedge clk) if (mem_we) tb_ram[mem_addr] <= mem_wdata;

  // Reference model state.
  logic [31:0] ref_ram [0:1023];
  logic [15:0] m_led;
  logic [31:0] m_seg, m_tload, m_tcount;
  logic        m_en, m_rel, m_ie, m_exp;
  logic [15:0] swq[$];

  typedef struct {
    logic [31:0] adr, rd, wdata, seg;
    logic [15:0] led;
    logic [9:0]  maddr;
    logic        we, irq;
  } exp_t;
  exp_t sbq[$];
  logic obs_valid;

  int n_chk, n_err;
  logic [15:0] swcur;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s adr=%h: got %h expected %h", name, a, act, expv);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >> 8) == 32'h00FF_FF00;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (is_ram(a)) return ref_ram[a[11:2]];
    if (is_mmio(a)) begin
      case (a[7:0])
        8'h00: return {16'd0, m_led};
        8'h04: return {16'd0, swq[0]};
        8'h08: return m_seg;
        8'h10: return TIMER ? {28'd0, m_ie, m_exp, m_rel, m_en} : 32'd0;
        8'h14: return TIMER ? m_tload : 32'd0;
        8'h18: return TIMER ? m_tcount : 32'd0;
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_led = 16'd0; m_seg = 32'd0; m_tload = 32'd0; m_tcount = 32'd0;
    m_en = 1'b0; m_rel = 1'b0; m_ie = 1'b0; m_exp = 1'b0;
    swq = {16'd0, 16'd0};
  endtask

  // Advance the model across one rising edge with the given bus inputs.
  task automatic m_edge(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic [15:0] s);
    logic [31:0] nt;
    logic        ne, wr;
    wr = we && is_mmio(a);
    if (we && is_ram(a)) ref_ram[a[11:2]] = wd;
    if (wr && a[7:0] == 8'h00) m_led = wd[15:0];
    if (wr && a[7:0] == 8'h08) m_seg = wd;
    void'(swq.pop_front());
    swq.push_back(s);
    if (TIMER) begin
      nt = m_tcount;
      if (wr && a[7:0] == 8'h14) nt = wd;
      else if (m_en && m_tcount != 0) nt = m_tcount - 1;
      else if (m_en && m_rel) nt = m_tload;
      ne = m_exp;
      if (wr && a[7:0] == 8'h10 && wd[2]) ne = 1'b0;
      if (m_tcount == 1 && nt == 0) ne = 1'b1;
      if (wr && a[7:0] == 8'h10) begin m_en = wd[0]; m_rel = wd[1]; m_ie = wd[3]; end
      if (wr && a[7:0] == 8'h14) m_tload = wd;
      m_tcount = nt;
      m_exp = ne;
    end
  endtask

  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic we);
    exp_t e;
    @(posedge clk); #1;
    adr = a; writedata = wd; MemWrite = we; sw = swcur;
    e.adr = a; e.rd = m_read(a); e.wdata = wd; e.seg = m_seg; e.led = m_led;
    e.maddr = a[11:2]; e.we = we && is_ram(a); e.irq = TIMER && m_exp && m_ie;
    sbq.push_back(e);
    obs_valid = 1'b1;
    m_edge(a, wd, we, swcur);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (obs_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("readdata",  e.adr, readdata, e.rd);
      chk("mem_we",    e.adr, {31'd0, mem_we}, {31'd0, e.we});
      chk("mem_addr",  e.adr, {22'd0, mem_addr}, {22'd0, e.maddr});
      chk("mem_wdata", e.adr, mem_wdata, e.wdata);
      chk("led",       e.adr, {16'd0, led}, {16'd0, e.led});
      chk("seg",       e.adr, seg, e.seg);
      chk("irq",       e.adr, {31'd0, irq}, {31'd0, e.irq});
    end
  end

  function automatic logic [31:0] rand_adr();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2:    return 32'($urandom_range(0, 15)) * 4;
      3:          return 32'h0000_0FFC;
      4, 5, 6, 7: return 32'hFFFF_0000 + 32'($urandom_range(0, 8)) * 4;
      default: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000_1000;
          1: return 32'h8000_0000;
          2: return 32'hFFFF_0100;
          3: return 32'h0001_0000;
          default: return 32'hFFFE_0000;
        endcase
      end
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, wd;
    logic        we;
    for (int i = 0; i < 1024; i++) begin
      tb_ram[i]  = 32'(i) * 32'h9E37_79B1;
      ref_ram[i] = 32'(i) * 32'h9E37_79B1;
    end
    n_chk = 0; n_err = 0; obs_valid = 1'b0;
    adr = 32'hFFFF_0010; writedata = 32'd0; MemWrite = 1'b0; sw = 16'd0; swcur = 16'd0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_led",   adr, {16'd0, led}, 32'd0);
    chk("rst_seg",   adr, seg, 32'd0);
    chk("rst_irq",   adr, {31'd0, irq}, 32'd0);
    chk("rst_tctrl", adr, readdata, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    m_reset();

    // RAM store then load.
    cycle(32'h0000_0040, 32'hDEAD_BEEF, 1'b1);
    cycle(32'h0000_0040, 32'h0000_0000, 1'b0);
    cycle(32'h0000_0FFC, 32'h1357_9BDF, 1'b1);
    cycle(32'h0000_0FFC, 32'h0000_0000, 1'b0);

    // LED write and switch synchronizer.
    cycle(32'hFFFF_0000, 32'h0001_A5A5, 1'b1);
    swcur = 16'h1234;
    repeat (3) cycle(32'hFFFF_0004, 32'd0, 1'b0);
    cycle(32'hFFFF_0008, 32'hCAFE_F00D, 1'b1);
    cycle(32'hFFFF_0008, 32'd0, 1'b0);

    // One-shot timer.
    cycle(32'hFFFF_0014, 32'd3, 1'b1);
    cycle(32'hFFFF_0010, 32'h9, 1'b1);
    repeat (6) cycle(32'hFFFF_0018, 32'd0, 1'b0);
    cycle(32'hFFFF_0010, 32'hD, 1'b1);
    cycle(32'hFFFF_0010, 32'd0, 1'b0);

    // Auto-reload.
    cycle(32'hFFFF_0010, 32'h0, 1'b1);
    cycle(32'hFFFF_0014, 32'd2, 1'b1);
    cycle(32'hFFFF_0010, 32'h3, 1'b1);
    repeat (8) cycle(32'hFFFF_0018, 32'd0, 1'b0);
    cycle(32'hFFFF_0010, 32'd0, 1'b0);

    // Clear colliding with expiry.
    cycle(32'hFFFF_0010, 32'h4, 1'b1);
    cycle(32'hFFFF_0014, 32'd3, 1'b1);
    cycle(32'hFFFF_0010, 32'h1, 1'b1);
    for (int i = 0; i < 8 && m_tcount != 32'd1; i++) cycle(32'hFFFF_0018, 32'd0, 1'b0);
    cycle(32'hFFFF_0010, 32'h5, 1'b1);
    cycle(32'hFFFF_0010, 32'd0, 1'b0);

    // Unmapped store.
    cycle(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    cycle(32'h8000_0000, 32'd0, 1'b0);
    cycle(32'h0000_0000, 32'd0, 1'b0);
    cycle(32'hFFFF_0000, 32'd0, 1'b0);

    // Asynchronous reset in the middle of a count.
    cycle(32'hFFFF_0000, 32'h0000_5A5A, 1'b1);
    cycle(32'hFFFF_0014, 32'd8, 1'b1);
    cycle(32'hFFFF_0010, 32'h9, 1'b1);
    for (int i = 0; i < 8 && m_tcount != 32'd5; i++) cycle(32'hFFFF_0018, 32'd0, 1'b0);
    @(posedge clk); #1;
    obs_valid = 1'b0;
    adr = 32'hFFFF_0018; MemWrite = 1'b0; swcur = 16'd0; sw = 16'd0;
    #1;
    chk("pre_rst_tcount", adr, readdata, m_tcount);
    chk("pre_rst_irq",    adr, {31'd0, irq}, {31'd0, TIMER && m_exp && m_ie});
    chk("pre_rst_led",    adr, {16'd0, led}, 32'h0000_5A5A);
    rst = 1'b0;
    #1;
    chk("async_tcount", adr, readdata, 32'd0);
    chk("async_irq",    adr, {31'd0, irq}, 32'd0);
    chk("async_led",    adr, {16'd0, led}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    m_reset();
    repeat (4) cycle(32'hFFFF_0018, 32'd0, 1'b0);
    cycle(32'hFFFF_0010, 32'd0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      a  = rand_adr();
      we = ($urandom_range(0, 9) < 3);
      wd = $urandom();
      if (a == 32'hFFFF_0014) wd = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) swcur = 16'($urandom());
      cycle(a, wd, we);
    end

    @(posedge clk);
    @(negedge clk); #1;
    chk("sb_drain", 32'd0, 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning RAM word-address width (RAM size 2^RAM_AW words).
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; asynchronous, active-low.
- adr  in  32  byte address from the CPU.
- writedata  in  32  store data from the CPU.
- MemWrite  in  1  CPU store strobe.
- readdata  out  32  load/fetch data to the CPU.
- mem_we  out  1  RAM write enable.
- mem_addr  out  RAM_AW  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data (combinational RAM).
- sw  in  16  board switches (asynchronous).
- led  out  16  LED register.
- seg  out  32  seven-segment display value register.
- irq  out  1  timer interrupt.

Function
REQ-003 SHALL decode adr as RAM when adr[31:16]==16'h0000 and adr[15:RAM_AW+2]==0; as MMIO when adr[31:8]==24'hFFFF00; otherwise as unmapped.
REQ-004 SHALL drive mem_addr=adr[RAM_AW+1:2] and mem_wdata=writedata; mem_we=MemWrite & RAM-hit.
REQ-005 SHALL make readdata purely combinational from adr in the same cycle:
- RAM hit: mem_rdata.
- MMIO hit: register value per REQ-006.
- unmapped: 32'h0.
REQ-006 SHALL implement the MMIO map (word offsets); reserved bits read 0:
- 0x00 LED: RW, bits[15:0].
- 0x04 SW: RO, synchronized sw.
- 0x08 SEG: RW, 32 bits.
- 0x10 TCTRL: RW. bit0 EN, bit1 RELOAD, bit3 IE; bit2 EXP is read-only status, write 1 to clear.
- 0x14 TLOAD: RW, 32 bits.
- 0x18 TCOUNT: RO.
- other offsets: read 0.
REQ-007 SHALL perform MMIO register writes at the rising clk edge when MemWrite is high and the address hits; writes to RO, reserved or unmapped addresses SHALL have no effect.
REQ-008 SHALL synchronize sw through two flops; a change on sw is visible at SW no later than 2 rising edges after it settles.
REQ-009 Timer, evaluated each rising edge, highest priority first:
- write to TLOAD: TLOAD<=wdata and TCOUNT<=wdata.
- else EN=1 and TCOUNT!=0: TCOUNT<=TCOUNT-1.
- else EN=1 and TCOUNT==0 and RELOAD=1: TCOUNT<=TLOAD.
- otherwise: TCOUNT holds.
REQ-010 SHALL set EXP on the edge where TCOUNT goes 1->0; if that set coincides with a W1C clear, the set SHALL win.
REQ-011 SHALL drive irq=EXP & IE combinationally from the registers; irq SHALL stay high until EXP is cleared or IE is written 0.
REQ-012 With EN=0, TCOUNT SHALL freeze and a TLOAD write SHALL still load TCOUNT.
REQ-013 SHALL never wrap TCOUNT below 0; with RELOAD=0 it SHALL stay at 0.

Reset
REQ-014 On rst low, SHALL clear immediately: led, seg, TCTRL, EXP, TLOAD, TCOUNT and the sw synchronizer flops; irq SHALL then read 0.
REQ-015 Reset asserted mid-count SHALL abort the count; after release, the timer SHALL stay idle until software reprograms it.
REQ-016 Combinational outputs (readdata, mem_we, mem_addr, mem_wdata) are not reset and SHALL follow their inputs.

Configuration
REQ-017 SHALL compile the timer only when macro MMIO_TIMER_EN is defined.
REQ-018 With MMIO_TIMER_EN: REQ-009 to REQ-013 apply.
REQ-019 Without MMIO_TIMER_EN: offsets 0x10-0x18 read 0, writes to them are ignored, irq is constant 0, and no timer flops are generated.

Structure
REQ-020 SHALL place the following in shared package mmio_pkg: MMIO base 32'hFFFF0000; register offset constants; TCTRL bit indices (EN=0, RELOAD=1, EXP=2, IE=3).
REQ-021 SHALL implement the timer as sub-module mmio_timer (TCTRL/TLOAD/TCOUNT/EXP, irq), instantiated only under MMIO_TIMER_EN.

Verification
REQ-022 RAM store/load: adr=0x40, writedata=0xDEADBEEF, MemWrite=1 -> mem_we=1, mem_addr=0x10; then MemWrite=0, mem_rdata=0xDEADBEEF -> readdata=0xDEADBEEF in the same cycle.
REQ-023 MMIO LED/SW: write 0x0001A5A5 to 0xFFFF0000 -> led=0xA5A5 after the edge, mem_we=0; sw=0x1234 -> read 0xFFFF0004 returns 0x00001234 within 2 cycles.
REQ-024 One-shot timer: TLOAD=3, then TCTRL=0x9 -> TCOUNT 3,2,1,0 on successive edges; EXP=1 and irq=1 at 0, then TCOUNT stays 0; writing TCTRL=0xD clears EXP and irq.
REQ-025 Auto-reload: TLOAD=2, TCTRL=0x3 -> TCOUNT sequence 2,1,0,2,1,0; EXP sets on the first 1->0.
REQ-026 Collision/unmapped: W1C clear on the same edge as 1->0 -> EXP=1; store to 0x80000000 -> no register, RAM or led change, and a read returns 0.
REQ-027 Async reset: assert rst mid-count with TCOUNT=5 -> TCOUNT=0, led=0, irq=0 without waiting for a clk edge; build without MMIO_TIMER_EN -> read 0xFFFF0018 returns 0 and irq stays 0.
